leaf_stream_fifo: RTL



---
 rtl/leaf_stream_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/leaf_stream_fifo.sv
// Synchronous valid/ready FIFO decoupling a producer from a consumer in one clock domain.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module leaf_stream_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] AF_THRSH = PW'(AF_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     count_next;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // in_ready deliberately ignores out_ready: a full FIFO refuses a push even while popping.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign count     = wr_ptr - rd_ptr;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + PTR_ONE;
            2'b01:   count_next = count - PTR_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= in_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            almost_full <= (count_next >= AF_THRSH);
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
